// File: rtl/fc_layer_seq.sv
// fc_layer_seq
//   Sequential fully-connected layer. One input vector of IN_SIZE signed
//   elements is multiplied by an OUT_SIZE x IN_SIZE weight matrix read from
//   an external synchronous memory, LANES neurons at a time. Each neuron's
//   sum of bias and dot-product is requantised, which means an arithmetic
//   right shift, an optional ReLU and saturation to DATA_W bits.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   s_valid/s_ready   input vector handshake (s_ready only in IDLE)
//   s_data            IN_SIZE packed signed elements
//   s_bias            OUT_SIZE packed signed biases
//   s_shift, s_relu   requantisation controls, latched with s_data
//   w_addr/w_rdata    weight memory port; read data returns one cycle later
//   m_valid/m_ready   output vector handshake
//   m_data            OUT_SIZE packed signed results
//   busy              high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for an input vector, s_ready high
// MAC   | issuing weight reads for the current lane group, one per cycle
// DRAIN | absorbing the final read return of the group
// WB    | requantising the accumulators into the group's m_data slots
// OUT   | presenting m_data until downstream accepts
module fc_layer_seq #(
  parameter int IN_SIZE  = 128,
  parameter int OUT_SIZE = 10,
  parameter int LANES    = 2,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  localparam int G       = OUT_SIZE / LANES,
  localparam int AW      = (G * IN_SIZE > 1) ? $clog2(G * IN_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [IN_SIZE*DATA_W-1:0]    s_data,
  input  logic [OUT_SIZE*DATA_W-1:0]   s_bias,
  input  logic [4:0]                   s_shift,
  input  logic                         s_relu,
  output logic [AW-1:0]                w_addr,
  input  logic [LANES*DATA_W-1:0]      w_rdata,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [OUT_SIZE*DATA_W-1:0]   m_data,
  output logic                         busy
);

  localparam int J_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int G_W = (G > 1) ? $clog2(G) : 1;
  localparam logic [J_W-1:0] J_LAST = J_W'(IN_SIZE - 1);
  localparam logic [G_W-1:0] G_LAST = G_W'(G - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WB, OUT} state_t;

  state_t                      state_q, state_d;
  logic [G_W-1:0]              g_q, g_d;
  logic [J_W-1:0]              j_q, j_d;
  logic [J_W-1:0]              rd_j_q, rd_j_d;
  logic                        rd_pend_q, rd_pend_d;
  logic [AW-1:0]               w_addr_q, w_addr_d;
  logic [IN_SIZE*DATA_W-1:0]   in_q, in_d;
  logic [OUT_SIZE*DATA_W-1:0]  bias_q, bias_d;
  logic [4:0]                  shift_q, shift_d;
  logic                        relu_q, relu_d;
  logic [OUT_SIZE*DATA_W-1:0]  m_data_q, m_data_d;
  logic                        m_valid_q, m_valid_d;
  logic signed [ACC_W-1:0]     acc_q [LANES];
  logic signed [ACC_W-1:0]     acc_d [LANES];

  // Group start: accumulators are loaded with the bias of group g_start,
  // taken from the live input bus on acceptance or the latched copy later.
  logic                        start_grp;
  logic [G_W-1:0]              g_start;
  logic [OUT_SIZE*DATA_W-1:0]  bias_src;

  logic signed [DATA_W-1:0]    in_sel;
  logic signed [DATA_W-1:0]    w_lane  [LANES];
  logic signed [2*DATA_W-1:0]  prod    [LANES];
  logic signed [ACC_W-1:0]     shifted [LANES];
  logic signed [DATA_W-1:0]    res     [LANES];

  // Datapath: product for the returning read, requantised lane results.
  always_comb begin
    in_sel = '0;
    for (int jj = 0; jj < IN_SIZE; jj++) begin
      if (rd_j_q == J_W'(jj)) in_sel = in_q[jj*DATA_W +: DATA_W];
    end
    for (int l = 0; l < LANES; l++) begin
      w_lane[l]  = w_rdata[l*DATA_W +: DATA_W];
      prod[l]    = (2*DATA_W)'(in_sel) * (2*DATA_W)'(w_lane[l]);
      shifted[l] = acc_q[l] >>> shift_q;
      if (relu_q && shifted[l][ACC_W-1]) shifted[l] = '0;
      if (shifted[l] > SAT_MAX)      res[l] = SAT_MAX[DATA_W-1:0];
      else if (shifted[l] < SAT_MIN) res[l] = SAT_MIN[DATA_W-1:0];
      else                           res[l] = shifted[l][DATA_W-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    j_d       = j_q;
    rd_j_d    = j_q;
    rd_pend_d = 1'b0;
    w_addr_d  = w_addr_q;
    in_d      = in_q;
    bias_d    = bias_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    start_grp = 1'b0;
    g_start   = g_q;
    bias_src  = bias_q;
    for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l];

    // A read issued last cycle returns now; it always belongs to the
    // current group because a group ends with DRAIN and WB.
    if (rd_pend_q) begin
      for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l] + ACC_W'(prod[l]);
    end

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          in_d      = s_data;
          bias_d    = s_bias;
          shift_d   = s_shift;
          relu_d    = s_relu;
          bias_src  = s_bias;
          g_d       = '0;
          j_d       = '0;
          w_addr_d  = '0;
          start_grp = 1'b1;
          g_start   = '0;
          state_d   = MAC;
        end
      end
      MAC: begin
        rd_pend_d = 1'b1;
        rd_j_d    = j_q;
        if (j_q == J_LAST) begin
          state_d = DRAIN;
        end else begin
          j_d      = j_q + J_W'(1);
          w_addr_d = w_addr_q + AW'(1);
        end
      end
      DRAIN: begin
        state_d = WB;
      end
      WB: begin
        for (int gg = 0; gg < G; gg++) begin
          if (g_q == G_W'(gg)) begin
            for (int l = 0; l < LANES; l++)
              m_data_d[(gg*LANES+l)*DATA_W +: DATA_W] = res[l];
          end
        end
        if (g_q == G_LAST) begin
          m_valid_d = 1'b1;
          state_d   = OUT;
        end else begin
          // Group addresses are contiguous, so the next group starts one
          // past the last address of this one.
          g_d       = g_q + G_W'(1);
          j_d       = '0;
          w_addr_d  = w_addr_q + AW'(1);
          start_grp = 1'b1;
          g_start   = g_q + G_W'(1);
          state_d   = MAC;
        end
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_grp) begin
      for (int gg = 0; gg < G; gg++) begin
        if (g_start == G_W'(gg)) begin
          for (int l = 0; l < LANES; l++)
            acc_d[l] = ACC_W'($signed(bias_src[(gg*LANES+l)*DATA_W +: DATA_W]));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      g_q       <= '0;
      j_q       <= '0;
      rd_j_q    <= '0;
      rd_pend_q <= 1'b0;
      w_addr_q  <= '0;
      in_q      <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      j_q       <= j_d;
      rd_j_q    <= rd_j_d;
      rd_pend_q <= rd_pend_d;
      w_addr_q  <= w_addr_d;
      in_q      <= in_d;
      bias_q    <= bias_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
    end
  end

  assign s_ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign w_addr  = w_addr_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq
//   Directed bench for fc_layer_seq with IN_SIZE=4, OUT_SIZE=4, LANES=2,
//   DATA_W=8. A synchronous ROM model answers weight reads one cycle after
//   the address. Expected values are hand-computed constants.
module tb_fc_layer_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] s_bias;
  logic [4:0]  s_shift;
  logic        s_relu;
  logic [2:0]  w_addr;
  logic [15:0] w_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        busy;

  logic [15:0] mem [8];
  int errors = 0;
  int checks = 0;
  int lat;

  fc_layer_seq #(.IN_SIZE(4), .OUT_SIZE(4), .LANES(2), .DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_bias(s_bias), .s_shift(s_shift), .s_relu(s_relu),
    .w_addr(w_addr), .w_rdata(w_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) w_rdata <= mem[w_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 8; i++) mem[i] = w;
  endtask

  task automatic accept(input logic [31:0] d, input logic [31:0] b,
                        input logic [4:0] sh, input logic r);
    int n;
    s_data = d; s_bias = b; s_shift = sh; s_relu = r; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 50) begin tick(); n++; end
    chk("accept_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!m_valid && l < 200) begin tick(); l++; end
  endtask

  task automatic handshake(input string tag);
    m_ready = 1'b1;
    tick();
    chk({tag, "_mvalid_low"}, m_valid, 1'b0);
    chk({tag, "_sready_back"}, s_ready, 1'b1);
    m_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] d, input logic [31:0] b,
                         input logic [4:0] sh, input logic r, input logic [31:0] exp);
    accept(d, b, sh, r);
    chk({tag, "_busy"}, busy, 1'b1);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 12);
    chk({tag, "_data"}, m_data, exp);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_bias = '0;
    s_shift = '0; s_relu = 1'b0; m_ready = 1'b0;
    fill(16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_sready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mvalid", m_valid, 1'b0);
    chk("rst_mdata", m_data, 32'h0);
    chk("rst_waddr", w_addr, 3'd0);

    // All ones: 4 per neuron.
    fill(16'h0101);
    run_vec("ones", 32'h01010101, 32'h0, 5'd0, 1'b0, 32'h04040404);

    // Saturation and shift.
    fill(16'h7F7F);
    run_vec("sat_pos", 32'h7F7F7F7F, 32'h0, 5'd0, 1'b0, 32'h7F7F7F7F);
    fill(16'h8181);
    run_vec("sat_neg", 32'h7F7F7F7F, 32'h0, 5'd0, 1'b0, 32'h80808080);
    fill(16'h7F7F);
    run_vec("shift9", 32'h7F7F7F7F, 32'h0, 5'd9, 1'b0, 32'h7E7E7E7E);

    // -5 with and without ReLU.
    fill(16'hFBFB);
    run_vec("neg5", 32'h00000001, 32'h0, 5'd0, 1'b0, 32'hFBFBFBFB);
    run_vec("relu", 32'h00000001, 32'h0, 5'd0, 1'b1, 32'h00000000);

    // Distinct weights/bias per neuron: in={1,2,3,4},
    // W0=1, W1=2, W2=-1, W3[j]=j, bias={10,-3,5,0} -> {20,17,-5,20}.
    for (int i = 0; i < 4; i++) mem[i] = 16'h0201;
    mem[4] = 16'h00FF; mem[5] = 16'h01FF; mem[6] = 16'h02FF; mem[7] = 16'h03FF;
    accept(32'h04030201, 32'h0005FD0A, 5'd0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k < 4) chk($sformatf("mix_addr_k%0d", k), w_addr, k);
      else if (k >= 6 && k < 10) chk($sformatf("mix_addr_k%0d", k), w_addr, k - 2);
      tick();
    end
    chk("mix_mvalid_at_12", m_valid, 1'b1);
    chk("mix_data", m_data, 32'h14FB1114);

    // Stall in OUT with s_valid asserted.
    s_data = 32'h11111111; s_bias = 32'h22222222; s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("stall_data_%0d", k), m_data, 32'h14FB1114);
      chk($sformatf("stall_sready_%0d", k), s_ready, 1'b0);
    end
    chk("stall_mvalid", m_valid, 1'b1);
    m_ready = 1'b1;
    tick();
    chk("stall_hs_mvalid", m_valid, 1'b0);
    chk("stall_hs_sready", s_ready, 1'b1);
    s_valid = 1'b0; m_ready = 1'b0;
    tick();
    chk("stall_no_accept", busy, 1'b0);
    chk("retain_data", m_data, 32'h14FB1114);

    // Reset in the middle of a computation.
    fill(16'h0101);
    accept(32'h01010101, 32'h0, 5'd0, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_mvalid", m_valid, 1'b0);
    chk("midrst_mdata", m_data, 32'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_waddr", w_addr, 3'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_sready", s_ready, 1'b1);
    run_vec("after_rst", 32'h01010101, 32'h0, 5'd0, 1'b0, 32'h04040404);

    // Back-to-back with m_ready tied high. B: in all 2, bias {1,2,3,4}.
    m_ready = 1'b1;
    s_data = 32'h01010101; s_bias = 32'h0; s_shift = 5'd0; s_relu = 1'b0;
    s_valid = 1'b1;
    chk("b2b_ready_a", s_ready, 1'b1);
    tick();
    s_data = 32'h02020202; s_bias = 32'h04030201;
    wait_out(lat);
    chk("b2b_lat_a", lat, 12);
    chk("b2b_data_a", m_data, 32'h04040404);
    tick();
    chk("b2b_hs_mvalid", m_valid, 1'b0);
    chk("b2b_hs_sready", s_ready, 1'b1);
    tick();
    chk("b2b_accept_b_busy", busy, 1'b1);
    chk("b2b_accept_b_sready", s_ready, 1'b0);
    s_valid = 1'b0;
    wait_out(lat);
    chk("b2b_lat_b", lat, 12);
    chk("b2b_data_b", m_data, 32'h0C0B0A09);
    tick();
    chk("b2b_end_mvalid", m_valid, 1'b0);
    m_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
